booth_arb: RTL and testbench
============================

BOOTH_ARB -- requirements
Module: booth_arb

Interface
REQ-001 SHALL have parameter RR_INIT, default 0, meaning the requester index (0/1) holding round-robin priority after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  each requester has a multiply operation pending.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16  signed two's-complement operands.
REQ-007 SHALL have ports rsp0_valid/rsp1_valid  output  1  product available for that requester.
REQ-008 SHALL have ports rsp0_ready/rsp1_ready  input  1  requester consumes the product.
REQ-009 SHALL have port rsp_p  output  32  signed product, shared by both responders.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL share one 16x16 signed Booth multiplier between two requesters using the FSM IDLE -> CALC -> DONE -> IDLE.
REQ-012 IDLE: grant = sole valid requester; if both are valid, grant = RR pointer; reqN_ready = (state==IDLE) && grantN, combinational; the other ready SHALL be 0.
REQ-013 On a req handshake: latch a, b and owner id, then go to CALC.
REQ-014 CALC (one cycle): register the multiplier output into the result register, then go to DONE.
REQ-015 DONE: assert rspN_valid for the owner only; hold rsp_p stable until rspN_ready=1; on that handshake set the RR pointer to the non-owner and go to IDLE.
REQ-016 rsp_p SHALL be the full 32-bit signed product with no truncation; (-32768)*(-32768) = 0x40000000.
REQ-017 Latency SHALL be rsp valid 2 cycles after the req handshake; minimum issue interval 3 cycles.
REQ-018 A requester SHALL hold valid and operands stable until ready; the block samples operands only at the handshake.
REQ-019 Requests arriving while busy SHALL see ready=0 and wait; no request is dropped or reordered within a requester.
REQ-020 rsp_p SHALL read 0 while no rsp valid is asserted.

Reset
REQ-021 With rst=1 at a clock edge: state=IDLE, RR pointer=RR_INIT, result register=0, rsp0_valid=rsp1_valid=0, busy=0.
REQ-022 Reset in CALC or DONE SHALL abort the operation with no response issued; the requester SHALL re-request.

Configuration
REQ-023 Macro BOOTH_ARB_OUTREG_EN defined: insert a CALC2 state plus a second pipeline register between the multiplier and the result register; latency 3, issue interval 4.
REQ-024 Macro BOOTH_ARB_OUTREG_EN undefined: FSM is exactly IDLE/CALC/DONE per REQ-017.

Structure
REQ-025 Package booth_pkg SHALL hold OP_W=16, PROD_W=32 and the FSM state enum (IDLE, CALC, CALC2, DONE).
REQ-026 SHALL instantiate the existing booth16bit combinational multiplier (ports a, b, p) as its only sub-module.

Verification
REQ-027 rst held 2 cycles with all req valid=0 -> busy=0, rsp*_valid=0, rsp_p=0.
REQ-028 req0 a=-126, b=-1 at T -> rsp0_valid at T+2, rsp_p=0x0000007E; rsp1_valid stays 0.
REQ-029 req0 (0x7FFF, 0x7FFF) and req1 (1, 1) valid together, RR_INIT=0 -> rsp0 first with 0x3FFF0001, then rsp1 with 0x00000001.
REQ-030 rsp0_ready low for 5 cycles in DONE -> rsp_p stable, req1_ready=0 throughout, busy=1.
REQ-031 rst asserted during CALC -> IDLE next cycle, no rsp valid, RR pointer=RR_INIT.
REQ-032 BOOTH_ARB_OUTREG_EN defined, req1 (-32768, -32768) at T -> rsp1_valid at T+3, rsp_p=0x40000000.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared widths and FSM state encoding for the booth_arb multiplier arbiter.
package booth_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CALC2 = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/booth16bit.sv
// Combinational 16x16 signed radix-2 Booth multiplier producing a full 32-bit product.
module booth16bit
  import booth_pkg::*;
(
  input  logic signed [OP_W-1:0]   a,
  input  logic signed [PROD_W/2-1:0] b,
  output logic signed [PROD_W-1:0] p
);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] acc;
  logic                     prev;

  // Recode each multiplier bit pair into add/subtract of the shifted multiplicand.
  always_comb begin
    a_ext = {{(PROD_W-OP_W){a[OP_W-1]}}, a};
    acc   = {PROD_W{1'b0}};
    prev  = 1'b0;
    for (int i = 0; i < OP_W; i++) begin
      case ({b[i], prev})
        2'b01:   acc = acc + (a_ext <<< i);
        2'b10:   acc = acc - (a_ext <<< i);
        default: acc = acc;
      endcase
      prev = b[i];
    end
  end

  assign p = acc;

endmodule

// File: rtl/booth_arb.sv
// Two-requester round-robin arbiter sharing one Booth multiplier (IDLE -> CALC -> DONE).
// Defining BOOTH_ARB_OUTREG_EN adds a CALC2 pipeline stage (latency 3, issue interval 4).
module booth_arb
  import booth_pkg::*;
#(
  parameter int unsigned RR_INIT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic                     req1_valid,
  output logic                     req0_ready,
  output logic                     req1_ready,
  input  logic signed [OP_W-1:0]   req0_a,
  input  logic signed [OP_W-1:0]   req0_b,
  input  logic signed [OP_W-1:0]   req1_a,
  input  logic signed [OP_W-1:0]   req1_b,
  output logic                     rsp0_valid,
  output logic                     rsp1_valid,
  input  logic                     rsp0_ready,
  input  logic                     rsp1_ready,
  output logic signed [PROD_W-1:0] rsp_p,
  output logic                     busy
);

  localparam logic RR_INIT_BIT = (RR_INIT != 32'd0);

  state_e                   state_q, state_d;
  logic                     rr_q, rr_d;
  logic                     owner_q, owner_d;
  logic signed [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic signed [PROD_W-1:0] res_q, res_d;
  logic signed [PROD_W-1:0] mul_p;
  logic                     grant0, grant1, rsp_hs;
`ifdef BOOTH_ARB_OUTREG_EN
  logic signed [PROD_W-1:0] pipe_q, pipe_d;
`endif

  booth16bit u_mul (
    .a (a_q),
    .b (b_q),
    .p (mul_p)
  );

  // Grant goes to the sole valid requester, or to the RR pointer on contention.
  assign grant0 = req0_valid && (!req1_valid || !rr_q);
  assign grant1 = req1_valid && (!req0_valid ||  rr_q);
  assign rsp_hs = owner_q ? rsp1_ready : rsp0_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and arbitration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= RR_INIT_BIT;
      owner_q <= 1'b0;
      a_q     <= {OP_W{1'b0}};
      b_q     <= {OP_W{1'b0}};
      res_q   <= {PROD_W{1'b0}};
`ifdef BOOTH_ARB_OUTREG_EN
      pipe_q  <= {PROD_W{1'b0}};
`endif
    end else begin
      rr_q    <= rr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifdef BOOTH_ARB_OUTREG_EN
      pipe_q  <= pipe_d;
`endif
    end
  end

  // Next-state and register-load logic.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
`ifdef BOOTH_ARB_OUTREG_EN
    pipe_d  = pipe_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d = grant1;
          a_d     = grant1 ? req1_a : req0_a;
          b_d     = grant1 ? req1_b : req0_b;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
`ifdef BOOTH_ARB_OUTREG_EN
        pipe_d  = mul_p;
        state_d = CALC2;
`else
        res_d   = mul_p;
        state_d = DONE;
`endif
      end
      CALC2: begin
`ifdef BOOTH_ARB_OUTREG_EN
        res_d   = pipe_q;
        state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (rsp_hs) begin
          rr_d    = ~owner_q;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req0_ready = (state_q == IDLE) && grant0;
    req1_ready = (state_q == IDLE) && grant1;
    rsp0_valid = (state_q == DONE) && !owner_q;
    rsp1_valid = (state_q == DONE) &&  owner_q;
    rsp_p      = (state_q == DONE) ? res_q : {PROD_W{1'b0}};
    busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_booth_arb.sv
// Self-checking bench for booth_arb: transaction-level reference model plus directed and random stimulus.
module tb_booth_arb;

`ifdef BOOTH_ARB_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int RR_INIT_TB = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0, rd0 = 1'b1, rd1 = 1'b1;
  logic signed [15:0] a0 = 16'sd0, b0 = 16'sd0, a1 = 16'sd0, b1 = 16'sd0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic signed [31:0] rsp_p;

  booth_arb #(.RR_INIT(RR_INIT_TB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req1_valid(v1),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rd0), .rsp1_ready(rd1),
    .rsp_p(rsp_p), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: one operation in flight, product = a*b, response LAT cycles after grant.
  logic        m_busy = 1'b0;
  logic        m_owner = 1'b0;
  logic        m_rr = (RR_INIT_TB != 0);
  logic [31:0] m_prod = 32'd0;
  int          m_hs = 0;
  int          cyc = 0;
  logic        seen = 1'b0;
  int          last_lat = 0;
  logic [31:0] last_p = 32'd0;
  logic        hs0 = 1'b0, hs1 = 1'b0;
  int          own_log[$];
  logic [31:0] p_log[$];

  task automatic cycle();
    logic g_any, g;
    @(negedge clk);
    hs0 = 1'b0;
    hs1 = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_rr   = (RR_INIT_TB != 0);
    end else if (!m_busy) begin
      g_any = v0 || v1;
      g     = (v0 && v1) ? m_rr : v1;
      check("ready0", 32'(req0_ready), 32'(g_any && !g));
      check("ready1", 32'(req1_ready), 32'(g_any && g));
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_rspv", 32'({rsp1_valid, rsp0_valid}), 32'd0);
      check("idle_p", rsp_p, 32'd0);
      if (g_any) begin
        m_busy  = 1'b1;
        m_owner = g;
        m_prod  = g ? 32'(int'(a1) * int'(b1)) : 32'(int'(a0) * int'(b0));
        m_hs    = cyc;
        seen    = 1'b0;
        if (g) hs1 = 1'b1; else hs0 = 1'b1;
      end
    end else begin
      check("busy_rdy", 32'({req1_ready, req0_ready}), 32'd0);
      check("busy", 32'(busy), 32'd1);
      if ((rsp0_valid || rsp1_valid) && !seen) begin
        seen     = 1'b1;
        last_lat = cyc - m_hs;
      end
      if (cyc - m_hs < LAT) begin
        check("early_rspv", 32'({rsp1_valid, rsp0_valid}), 32'd0);
        check("early_p", rsp_p, 32'd0);
      end else begin
        check("rspv", 32'({rsp1_valid, rsp0_valid}), m_owner ? 32'd2 : 32'd1);
        check("rsp_p", rsp_p, m_prod);
        if (m_owner ? rd1 : rd0) begin
          m_busy = 1'b0;
          m_rr   = !m_owner;
          last_p = rsp_p;
          own_log.push_back(int'(m_owner));
          p_log.push_back(rsp_p);
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [15:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 16'sh8000;
      1:       return 16'sh7FFF;
      2:       return 16'shFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (rnd) begin
        if (hs0 || !v0) begin
          v0 = ($urandom_range(0, 2) == 0);
          a0 = rand_op();
          b0 = rand_op();
        end
        if (hs1 || !v1) begin
          v1 = ($urandom_range(0, 2) == 0);
          a1 = rand_op();
          b1 = rand_op();
        end
        rd0 = ($urandom_range(0, 3) != 0);
        rd1 = ($urandom_range(0, 3) != 0);
      end else begin
        if (hs0) v0 = 1'b0;
        if (hs1) v1 = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset held two cycles with no requests.
    rst = 1'b1;
    run(2, 1'b0);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rspv", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    check("rst_p", rsp_p, 32'd0);
    run(1, 1'b0);

    // Single request from requester 0.
    own_log.delete(); p_log.delete();
    a0 = -16'sd126; b0 = -16'sd1; v0 = 1'b1;
    run(5, 1'b0);
    check("p_neg", last_p, 32'h0000007E);
    check("lat_neg", 32'(last_lat), 32'(LAT));
    check("n_neg", 32'(own_log.size()), 32'd1);
    check("own_neg", 32'(own_log[0]), 32'd0);

    // Contention straight after reset: requester 0 wins first.
    rst = 1'b1;
    run(1, 1'b0);
    rst = 1'b0;
    own_log.delete(); p_log.delete();
    a0 = 16'sh7FFF; b0 = 16'sh7FFF; v0 = 1'b1;
    a1 = 16'sd1;    b1 = 16'sd1;    v1 = 1'b1;
    run(4 * LAT + 4, 1'b0);
    check("n_rr", 32'(own_log.size()), 32'd2);
    check("own_rr0", 32'(own_log[0]), 32'd0);
    check("p_rr0", p_log[0], 32'h3FFF0001);
    check("own_rr1", 32'(own_log[1]), 32'd1);
    check("p_rr1", p_log[1], 32'h00000001);

    // Response back-pressure: requester 1 must wait while DONE is held.
    a0 = 16'sd3; b0 = 16'sd5; v0 = 1'b1;
    a1 = 16'sd7; b1 = 16'sd2; v1 = 1'b1;
    rd0 = 1'b0;
    run(LAT + 1, 1'b0);
    run(5, 1'b0);
    check("hold_r1", 32'(req1_ready), 32'd0);
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_p", rsp_p, 32'd15);
    check("hold_v0", 32'(rsp0_valid), 32'd1);
    rd0 = 1'b1;
    run(2 * LAT + 4, 1'b0);
    check("hold_p1", last_p, 32'd14);

    // Reset during CALC aborts and restores the RR pointer.
    a0 = 16'sd2; b0 = 16'sd2; v0 = 1'b1;
    run(LAT + 2, 1'b0);
    own_log.delete(); p_log.delete();
    a0 = 16'sd9; b0 = 16'sd9; v0 = 1'b1;
    run(1, 1'b0);
    rst = 1'b1;
    run(1, 1'b0);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rspv", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    check("abort_p", rsp_p, 32'd0);
    check("abort_nrsp", 32'(own_log.size()), 32'd0);
    a0 = 16'sd4; b0 = 16'sd4; v0 = 1'b1;
    a1 = 16'sd5; b1 = 16'sd5; v1 = 1'b1;
    #1;
    check("abort_rr0", 32'(req0_ready), 32'd1);
    check("abort_rr1", 32'(req1_ready), 32'd0);
    run(4 * LAT + 4, 1'b0);
    check("abort_p0", p_log[0], 32'd16);
    check("abort_p1", p_log[1], 32'd25);

    // Most negative operands.
    a1 = 16'sh8000; b1 = 16'sh8000; v1 = 1'b1;
    run(LAT + 3, 1'b0);
    check("p_min", last_p, 32'h40000000);
    check("lat_min", 32'(last_lat), 32'(LAT));

    // Random traffic against the model, then drain.
    run(400, 1'b1);
    v0 = 1'b0; v1 = 1'b0; rd0 = 1'b1; rd1 = 1'b1;
    run(LAT + 4, 1'b0);
    check("drain_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
